// File: rtl/train_ctrl_pkg.sv
// Shared state encoding, phase codes and per-phase select encodings for the
// training-phase sequencer.
package train_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FP_RUN, S_FP_DRN, S_BP_RUN, S_BP_DRN, S_WG_RUN, S_WG_DRN
  } state_e;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_FP   = 2'b01;
  localparam logic [1:0] PH_BP   = 2'b10;
  localparam logic [1:0] PH_WG   = 2'b11;

  localparam logic [3:0] SEL_M_IDLE  = 4'b0001;
  localparam logic [3:0] SEL_M_FP_S1 = 4'b0010;
  localparam logic [3:0] SEL_M_WG_S0 = 4'b1101;
  localparam logic [3:0] SEL_M_WG_S1 = 4'b1110;

  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_FP    = 2'b01;
  localparam logic [1:0] SEL_BP_S0 = 2'b01;
  localparam logic [1:0] SEL_BP_S1 = 2'b00;
  localparam logic [1:0] SEL_WG    = 2'b11;

  localparam logic [1:0] CUT_IDLE  = 2'b00;
  localparam logic [1:0] CUT_FP    = 2'b01;
  localparam logic [1:0] CUT_BP_S1 = 2'b10;

  localparam logic [1:0] INPREF_S0 = 2'b01;
  localparam logic [1:0] INPREF_S1 = 2'b00;
  localparam logic [1:0] INPREF_BP = 2'b11;

  localparam logic [2:0] INPREF_OUT_IDLE  = 3'b000;
  localparam logic [2:0] INPREF_OUT_S1    = 3'b010;
  localparam logic [2:0] INPREF_OUT_BP_S1 = 3'b100;
  localparam logic [2:0] INPREF_OUT_WG_S0 = 3'b001;

  function automatic logic [1:0] state_phase(input state_e s);
    case (s)
      S_FP_RUN, S_FP_DRN: state_phase = PH_FP;
      S_BP_RUN, S_BP_DRN: state_phase = PH_BP;
      S_WG_RUN, S_WG_DRN: state_phase = PH_WG;
      default:            state_phase = PH_IDLE;
    endcase
  endfunction

  function automatic logic is_run(input state_e s);
    is_run = (s == S_FP_RUN) || (s == S_BP_RUN) || (s == S_WG_RUN);
  endfunction

  // First enabled RUN state at phase index >= from (0 FP, 1 BP, 2 WG); IDLE if none.
  function automatic state_e run_from(input logic [2:0] en, input logic [1:0] from);
    run_from = S_IDLE;
    if (from <= 2'd2 && en[2]) run_from = S_WG_RUN;
    if (from <= 2'd1 && en[1]) run_from = S_BP_RUN;
    if (from == 2'd0 && en[0]) run_from = S_FP_RUN;
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter with a zero flag; used for run and drain timing.
module phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/train_phase_seq.sv
// FP -> BP -> WG training sequencer with per-phase run lengths, PE-clear drain,
// iteration count, abort and phase skipping. Outputs decode registered state only.
module train_phase_seq
  import train_ctrl_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int ITER_W  = 8,
  parameter int RST_CYC = 1
) (
  input  logic              clk,
  input  logic              fsm_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              stride,
  input  logic              bn_en,
  input  logic [CNT_W-1:0]  fp_len,
  input  logic [CNT_W-1:0]  bp_len,
  input  logic [CNT_W-1:0]  wg_len,
  input  logic [ITER_W-1:0] num_iter,
  output logic              busy,
  output logic              done,
  output logic [1:0]        phase,
  output logic [ITER_W-1:0] iter_idx,
  output logic              in_en,
  output logic              pe_clr,
  output logic [3:0]        select_m,
  output logic [1:0]        select,
  output logic [1:0]        en_cutting,
  output logic [1:0]        inpref_mode_selector,
  output logic [2:0]        inpref_mode_selector_output,
  output logic              buf_input_select,
  output logic              buf_output_select,
  output logic              parity
);
  localparam int DRN_W = (RST_CYC < 1) ? 1 : $clog2(RST_CYC + 1);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(RST_CYC - 1);

  state_e state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d, nit_q, nit_d;
  logic [CNT_W-1:0]  fp_q, fp_d, bp_q, bp_d, wg_q, wg_d;
  logic [CNT_W-1:0]  fp_e, bp_e, wg_e, run_val;
  logic stride_q, stride_d, bn_q, bn_d, parity_q, parity_d, done_q, done_d;
  logic [2:0] en_mask;
  logic run_ld, run_zero, drn_ld, drn_zero;
  state_e nxt;

  // While idle the next start uses live inputs; afterwards the latched copy.
  assign fp_e    = (state_q == S_IDLE) ? fp_len : fp_q;
  assign bp_e    = (state_q == S_IDLE) ? bp_len : bp_q;
  assign wg_e    = (state_q == S_IDLE) ? wg_len : wg_q;
  assign en_mask = {wg_e != '0, bp_e != '0, fp_e != '0};

  always_ff @(posedge clk or posedge fsm_rst)
    if (fsm_rst) begin
      state_q <= S_IDLE;  iter_q <= '0;  nit_q <= '0;
      fp_q <= '0;  bp_q <= '0;  wg_q <= '0;
      stride_q <= 1'b0;  bn_q <= 1'b0;  parity_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  iter_q <= iter_d;  nit_q <= nit_d;
      fp_q <= fp_d;  bp_q <= bp_d;  wg_q <= wg_d;
      stride_q <= stride_d;  bn_q <= bn_d;  parity_q <= parity_d;  done_q <= done_d;
    end

  always_comb begin
    state_d = state_q;  iter_d = iter_q;  nit_d = nit_q;  done_d = 1'b0;
    fp_d = fp_q;  bp_d = bp_q;  wg_d = wg_q;  stride_d = stride_q;  bn_d = bn_q;
    nxt = S_IDLE;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      iter_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          fp_d = fp_len;  bp_d = bp_len;  wg_d = wg_len;
          stride_d = stride;  bn_d = bn_en;
          nit_d = (num_iter == '0) ? ITER_W'(1) : num_iter;
          state_d = run_from(en_mask, 2'd0);
          done_d  = (state_d == S_IDLE);
        end
        S_FP_RUN: if (run_zero) state_d = S_FP_DRN;
        S_BP_RUN: if (run_zero) state_d = S_BP_DRN;
        S_WG_RUN: if (run_zero) state_d = S_WG_DRN;
        default: if (drn_zero) begin
          // Phase code doubles as the index of the following phase.
          nxt = run_from(en_mask, state_phase(state_q));
          if (nxt != S_IDLE) state_d = nxt;
          else if (iter_q < nit_q - ITER_W'(1)) begin
            iter_d  = iter_q + ITER_W'(1);
            state_d = run_from(en_mask, 2'd0);
          end else begin
            state_d = S_IDLE;
            iter_d  = '0;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    run_ld = is_run(state_d) && (state_d != state_q);
    drn_ld = !is_run(state_d) && (state_d != S_IDLE) && (state_d != state_q);
    case (state_d)
      S_FP_RUN: run_val = fp_e - CNT_W'(1);
      S_BP_RUN: run_val = bp_e - CNT_W'(1);
      S_WG_RUN: run_val = wg_e - CNT_W'(1);
      default:  run_val = '0;
    endcase
    parity_d = parity_q;
    if (state_d == S_IDLE || run_ld)  parity_d = 1'b0;
    else if (is_run(state_q) && stride_q) parity_d = ~parity_q;
  end

  phase_cnt #(.W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(fsm_rst), .load(run_ld), .en(is_run(state_q)),
    .load_val(run_val), .zero(run_zero)
  );

  phase_cnt #(.W(DRN_W)) u_drn_cnt (
    .clk(clk), .rst(fsm_rst), .load(drn_ld),
    .en(state_q != S_IDLE && !is_run(state_q)),
    .load_val(DRN_LOAD), .zero(drn_zero)
  );

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = done_q;
    phase    = state_phase(state_q);
    iter_idx = iter_q;
    in_en    = is_run(state_q);
    pe_clr   = busy && !in_en;
    parity   = parity_q;
    select_m = SEL_M_IDLE;  select = SEL_IDLE;  en_cutting = CUT_IDLE;
    inpref_mode_selector = INPREF_S0;  inpref_mode_selector_output = INPREF_OUT_IDLE;
    buf_input_select = 1'b0;  buf_output_select = 1'b0;
    case (phase)
      PH_FP: begin
        select = SEL_FP;  en_cutting = CUT_FP;  buf_input_select = bn_q;
        if (stride_q) begin
          select_m = SEL_M_FP_S1;  inpref_mode_selector = INPREF_S1;
          inpref_mode_selector_output = INPREF_OUT_S1;
        end
      end
      PH_BP: begin
        inpref_mode_selector = INPREF_BP;
        if (stride_q) begin
          select = SEL_BP_S1;  en_cutting = CUT_BP_S1;
          inpref_mode_selector_output = INPREF_OUT_BP_S1;
        end else select = SEL_BP_S0;
      end
      PH_WG: begin
        select = SEL_WG;  buf_output_select = 1'b1;
        if (stride_q) begin
          select_m = SEL_M_WG_S1;  inpref_mode_selector = INPREF_S1;
          inpref_mode_selector_output = INPREF_OUT_S1;
        end else begin
          select_m = SEL_M_WG_S0;  inpref_mode_selector_output = INPREF_OUT_WG_S0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_train_phase_seq.sv
// Self-checking bench for train_phase_seq: a trace-level model expands each
// configuration into the expected per-cycle output vector.
module tb_train_phase_seq;
  localparam int CNT_W = 6, ITER_W = 8, RST_CYC = 1;

  logic clk = 1'b0, fsm_rst = 1'b1, start = 1'b0, abort = 1'b0, stride = 1'b0, bn_en = 1'b0;
  logic [CNT_W-1:0] fp_len = '0, bp_len = '0, wg_len = '0;
  logic [ITER_W-1:0] num_iter = '0;
  logic busy, done, in_en, pe_clr, buf_in, buf_out, parity;
  logic [1:0] phase, select, en_cutting, inpref;
  logic [ITER_W-1:0] iter_idx;
  logic [3:0] select_m;
  logic [2:0] inpref_out;

  int tests = 0, fails = 0;
  logic [29:0] exp_q[$];
  logic [29:0] dut_vec;

  train_phase_seq #(.CNT_W(CNT_W), .ITER_W(ITER_W), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .fsm_rst(fsm_rst), .start(start), .abort(abort), .stride(stride),
    .bn_en(bn_en), .fp_len(fp_len), .bp_len(bp_len), .wg_len(wg_len),
    .num_iter(num_iter), .busy(busy), .done(done), .phase(phase), .iter_idx(iter_idx),
    .in_en(in_en), .pe_clr(pe_clr), .select_m(select_m), .select(select),
    .en_cutting(en_cutting), .inpref_mode_selector(inpref),
    .inpref_mode_selector_output(inpref_out), .buf_input_select(buf_in),
    .buf_output_select(buf_out), .parity(parity)
  );

  always #5 clk = ~clk;

  assign dut_vec = {busy, done, phase, iter_idx, in_en, pe_clr, select_m, select,
                    en_cutting, inpref, inpref_out, buf_in, buf_out, parity};

  // Expected output vector from the phase/stride tables.
  function automatic logic [29:0] exp_vec(input bit bsy, dn, input logic [1:0] ph,
      input logic [7:0] it, input bit ine, clr, str, bn, par);
    logic [3:0] sm; logic [1:0] sl, ct, ip; logic [2:0] io; bit bi, bo;
    sm = 4'b0001; sl = 2'b00; ct = 2'b00; ip = 2'b01; io = 3'b000; bi = 0; bo = 0;
    case (ph)
      2'd1: begin sl = 2'b01; ct = 2'b01; bi = bn;
        if (str) begin sm = 4'b0010; ip = 2'b00; io = 3'b010; end end
      2'd2: begin ip = 2'b11;
        if (str) begin sl = 2'b00; ct = 2'b10; io = 3'b100; end else sl = 2'b01; end
      2'd3: begin sl = 2'b11; bo = 1;
        if (str) begin sm = 4'b1110; ip = 2'b00; io = 3'b010; end
        else     begin sm = 4'b1101; io = 3'b001; end end
      default: ;
    endcase
    return {bsy, dn, ph, it, ine, clr, sm, sl, ct, ip, io, bi, bo, par};
  endfunction

  // Trace model: per iteration, each nonzero phase contributes len run cycles and
  // RST_CYC drain cycles; then one done cycle and one quiet idle cycle.
  task automatic build(input int fp, bp, wg, nit, input bit str, bn);
    int lens[3]; int n;
    lens = '{fp, bp, wg};
    n = (nit == 0) ? 1 : nit;
    exp_q.delete();
    if (fp + bp + wg != 0)
      for (int it = 0; it < n; it++)
        for (int p = 0; p < 3; p++)
          if (lens[p] > 0) begin
            for (int c = 0; c < lens[p]; c++)
              exp_q.push_back(exp_vec(1, 0, 2'(p + 1), 8'(it), 1, 0, str, bn, str && (c % 2 == 1)));
            for (int d = 0; d < RST_CYC; d++)
              exp_q.push_back(exp_vec(1, 0, 2'(p + 1), 8'(it), 0, 1, str, bn, str && (lens[p] % 2 == 1)));
          end
    exp_q.push_back(exp_vec(0, 1, 2'd0, 8'd0, 0, 0, 0, 0, 0));
    exp_q.push_back(exp_vec(0, 0, 2'd0, 8'd0, 0, 0, 0, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input int fp, bp, wg, nit, input bit str, bn);
    fp_len = CNT_W'(fp); bp_len = CNT_W'(bp); wg_len = CNT_W'(wg);
    num_iter = ITER_W'(nit); stride = str; bn_en = bn;
  endtask

  task automatic test_reset();
    fsm_rst = 1'b1; start = 1'b1; abort = 1'b0;
    tick(); tick();
    tests++;
    if (dut_vec !== exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL reset got %h exp %h", dut_vec, exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    start = 1'b0; fsm_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_cfg(8, 6, 8, 1, 0, 0); build(8, 6, 8, 1, 0, 0);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(); start = 1'b0; tests++;
      if (dut_vec !== exp_q[i]) begin
        fails++; $display("FAIL single cyc %0d got %h exp %h", i + 1, dut_vec, exp_q[i]);
      end
    end
  endtask

  task automatic test_stride1();
    set_cfg(9, 3, 4, 1, 1, 1); build(9, 3, 4, 1, 1, 1);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(); start = 1'b0; tests++;
      if (dut_vec !== exp_q[i]) begin
        fails++; $display("FAIL stride1 cyc %0d got %h exp %h", i + 1, dut_vec, exp_q[i]);
      end
    end
  endtask

  task automatic test_iter_skip();
    int dones = 0;
    set_cfg(2, 0, 3, 3, 0, 1); build(2, 0, 3, 3, 0, 1);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(); start = 1'b0; tests++;
      if (done) dones++;
      if (dut_vec !== exp_q[i]) begin
        fails++; $display("FAIL iter_skip cyc %0d got %h exp %h", i + 1, dut_vec, exp_q[i]);
      end
    end
    tests++;
    if (dones != 1) begin fails++; $display("FAIL iter_skip_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_abort();
    set_cfg(3, 5, 2, 2, 0, 0); build(3, 5, 2, 2, 0, 0);
    start = 1'b1;
    // indices 0-2 FP run, 3 drain, 4-6 BP run: abort during the third BP cycle
    for (int i = 0; i <= 6; i++) begin
      tick(); start = 1'b0; tests++;
      if (dut_vec !== exp_q[i]) begin
        fails++; $display("FAIL abort_pre cyc %0d got %h exp %h", i + 1, dut_vec, exp_q[i]);
      end
    end
    abort = 1'b1;
    tick(); abort = 1'b0; tests++;
    if (dut_vec !== exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL abort_idle got %h exp %h", dut_vec, exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    set_cfg(2, 1, 1, 1, 1, 0); build(2, 1, 1, 1, 1, 0);
    start = 1'b1; abort = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(); start = 1'b0; abort = 1'b0; tests++;
      if (dut_vec !== exp_q[i]) begin
        fails++; $display("FAIL abort_restart cyc %0d got %h exp %h", i + 1, dut_vec, exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    set_cfg(4, 3, 5, 1, 0, 0); build(4, 3, 5, 1, 0, 0);
    start = 1'b1;
    // indices 0-3 FP, 4 drain, 5-7 BP, 8 drain, 9-13 WG; reset lands in WG
    for (int i = 0; i <= 11; i++) begin
      tick(); start = (i == 2); tests++;
      if (i == 2) set_cfg(1, 7, 2, 4, 1, 1);
      if (dut_vec !== exp_q[i]) begin
        fails++; $display("FAIL busy_ignore cyc %0d got %h exp %h", i + 1, dut_vec, exp_q[i]);
      end
    end
    start = 1'b0;
    fsm_rst = 1'b1; #1; tests++;
    if (dut_vec !== exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL async_rst got %h exp %h", dut_vec, exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    tick(); fsm_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); tests++;
      if (dut_vec !== exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        fails++; $display("FAIL post_rst cyc %0d got %h exp idle", i, dut_vec);
      end
    end
  endtask

  task automatic test_all_zero();
    set_cfg(0, 0, 0, 5, 1, 1); build(0, 0, 0, 5, 1, 1);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(); start = 1'b0; tests++;
      if (dut_vec !== exp_q[i]) begin
        fails++; $display("FAIL all_zero cyc %0d got %h exp %h", i + 1, dut_vec, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int fp, bp, wg, nit; bit str, bn;
    for (int r = 0; r < 12; r++) begin
      fp = $urandom_range(0, 5); bp = $urandom_range(0, 5); wg = $urandom_range(0, 5);
      nit = $urandom_range(0, 3); str = 1'($urandom); bn = 1'($urandom);
      set_cfg(fp, bp, wg, nit, str, bn); build(fp, bp, wg, nit, str, bn);
      start = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        tick(); start = 1'b0; tests++;
        if (dut_vec !== exp_q[i]) begin
          fails++;
          $display("FAIL random run %0d cfg %0d/%0d/%0d n%0d s%0d cyc %0d got %h exp %h",
                   r, fp, bp, wg, nit, str, i + 1, dut_vec, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stride1();
    test_iter_skip();
    test_abort();
    test_busy_ignore();
    test_all_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
